bus_demux_1x4: RTL and testbench

- 1-to-4 request router between the RV32I core's load/store port and four memory-mapped slaves: data RAM, boot ROM, UART and GPIO.
- Decodes the request address against four base/mask regions and forwards the request to exactly one slave.
- Returns that slave's completion and read data to the core.
- Single outstanding transaction; registered outputs; unmapped or timed-out accesses return an error response.

---
 rtl/bus_demux_1x4_pkg.sv | 14 +
 rtl/bus_addr_decode.sv | 23 ++
 rtl/bus_demux_1x4.sv | 101 ++++++++++
 tb/tb_bus_demux_1x4.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bus_demux_1x4_pkg.sv
// bus_demux_1x4_pkg: shared state encoding and default memory map for the core-to-slave router
package bus_demux_1x4_pkg;
    localparam int SLAVE_COUNT = 4;
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
    localparam logic [31:0] DEF_BASE0 = 32'h0000_0000;
    localparam logic [31:0] DEF_MASK0 = 32'hFFFF_0000;
    localparam logic [31:0] DEF_BASE1 = 32'h1000_0000;
    localparam logic [31:0] DEF_MASK1 = 32'hFFFF_0000;
    localparam logic [31:0] DEF_BASE2 = 32'h2000_0000;
    localparam logic [31:0] DEF_MASK2 = 32'hFFFF_FF00;
    localparam logic [31:0] DEF_BASE3 = 32'h3000_0000;
    localparam logic [31:0] DEF_MASK3 = 32'hFFFF_FF00;
    localparam logic [15:0] DEF_TIMEOUT = 16'd255;
endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: priority base/mask region match, lowest region index wins on overlap
module bus_addr_decode
    import bus_demux_1x4_pkg::*;
#(
    parameter logic [31:0] BASE0 = DEF_BASE0,
    parameter logic [31:0] MASK0 = DEF_MASK0,
    parameter logic [31:0] BASE1 = DEF_BASE1,
    parameter logic [31:0] MASK1 = DEF_MASK1,
    parameter logic [31:0] BASE2 = DEF_BASE2,
    parameter logic [31:0] MASK2 = DEF_MASK2,
    parameter logic [31:0] BASE3 = DEF_BASE3,
    parameter logic [31:0] MASK3 = DEF_MASK3
) (
    input  logic [31:0] addr,
    output logic [1:0]  idx,
    output logic        hit
);
    logic [SLAVE_COUNT-1:0] m;
    assign m = {(addr & MASK3) == BASE3, (addr & MASK2) == BASE2,
                (addr & MASK1) == BASE1, (addr & MASK0) == BASE0};
    assign hit = |m;
    assign idx = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
endmodule

// File: rtl/bus_demux_1x4.sv
// bus_demux_1x4: routes one outstanding core load/store to one of four slaves
// and returns a registered response, with error on unmapped or timed-out accesses
module bus_demux_1x4
    import bus_demux_1x4_pkg::*;
#(
    parameter logic [31:0] BASE0 = DEF_BASE0,
    parameter logic [31:0] MASK0 = DEF_MASK0,
    parameter logic [31:0] BASE1 = DEF_BASE1,
    parameter logic [31:0] MASK1 = DEF_MASK1,
    parameter logic [31:0] BASE2 = DEF_BASE2,
    parameter logic [31:0] MASK2 = DEF_MASK2,
    parameter logic [31:0] BASE3 = DEF_BASE3,
    parameter logic [31:0] MASK3 = DEF_MASK3,
    parameter logic [15:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_req_valid,
    output logic                     m_req_ready,
    input  logic [31:0]              m_addr,
    input  logic                     m_we,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic                     m_rsp_valid,
    output logic                     m_rsp_err,
    output logic [31:0]              m_rdata,
    output logic [SLAVE_COUNT-1:0]   s_valid,
    input  logic [SLAVE_COUNT-1:0]   s_ready,
    output logic [31:0]              s_addr,
    output logic                     s_we,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [SLAVE_COUNT-1:0]   s_rvalid,
    input  logic [32*SLAVE_COUNT-1:0] s_rdata
);
    state_t state, state_nx;
    logic [1:0] sel, sel_nx, dec_idx;
    logic [15:0] cnt;
    logic dec_hit, accept, busy, done, tmo, err_nx, rsp_nx;

    bus_addr_decode #(
        .BASE0(BASE0), .MASK0(MASK0), .BASE1(BASE1), .MASK1(MASK1),
        .BASE2(BASE2), .MASK2(MASK2), .BASE3(BASE3), .MASK3(MASK3)
    ) u_decode (
        .addr(m_addr),
        .idx (dec_idx),
        .hit (dec_hit)
    );

    assign accept = state == IDLE && m_req_ready && m_req_valid;
    assign busy = state == REQ || state == RESP;
    assign done = state == RESP && s_rvalid[sel];
    // fire one cycle early so the registered error lands exactly TIMEOUT cycles after accept
    assign tmo = busy && !done && TIMEOUT != 16'd0 && ({1'b0, cnt} + 17'd2 >= {1'b0, TIMEOUT});
    assign sel_nx = accept ? dec_idx : sel;
    assign err_nx = (accept && !dec_hit) || tmo;
    assign rsp_nx = err_nx || done;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (dec_hit ? REQ : ERR) : IDLE;
            REQ:     state_nx = tmo ? IDLE : (s_ready[sel] ? RESP : REQ);
            RESP:    state_nx = rsp_nx ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= 2'd0;
            cnt         <= 16'd0;
            m_req_ready <= 1'b0;
            m_rsp_valid <= 1'b0;
            m_rsp_err   <= 1'b0;
            m_rdata     <= 32'd0;
            s_valid     <= '0;
            s_addr      <= 32'd0;
            s_we        <= 1'b0;
            s_wdata     <= 32'd0;
            s_wstrb     <= 4'd0;
        end else begin
            state       <= state_nx;
            sel         <= sel_nx;
            cnt         <= accept ? 16'd0 : (busy ? cnt + 16'd1 : cnt);
            // held low through the response cycle so a new request starts the cycle after
            m_req_ready <= state_nx == IDLE && !rsp_nx;
            m_rsp_valid <= rsp_nx;
            m_rsp_err   <= err_nx;
            m_rdata     <= (done && !s_we) ? s_rdata[{sel, 5'd0} +: 32] : 32'd0;
            s_valid     <= state_nx == REQ ? 4'b0001 << sel_nx : 4'd0;
            if (accept) begin
                s_addr  <= m_addr;
                s_we    <= m_we;
                s_wdata <= m_wdata;
                s_wstrb <= m_wstrb;
            end
        end
    end
endmodule

// File: tb/tb_bus_demux_1x4.sv
// tb_bus_demux_1x4: directed and randomized transactions against a latency/decode reference model
module tb_bus_demux_1x4;
    localparam logic [15:0] TMO = 16'd8;
    logic clk = 1'b0;
    logic rst, m_req_valid, m_req_ready, m_we, m_rsp_valid, m_rsp_err, s_we;
    logic [31:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata;
    logic [3:0] m_wstrb, s_valid, s_ready, s_wstrb, s_rvalid;
    logic [127:0] s_rdata;
    int checks = 0;
    int failures = 0;
    logic [31:0] bases [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    logic [31:0] masks [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00};

    bus_demux_1x4 #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rsp_valid(m_rsp_valid), .m_rsp_err(m_rsp_err), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_we(s_we),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & masks[i]) == bases[i]) return i;
        return -1;
    endfunction

    // Called at a negedge with the router idle; returns at the negedge where it is idle again.
    task automatic transact(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                            input logic [3:0] ws, input int rdy, input int rv,
                            input logic [31:0] rd, input bit noise);
        int r, lat, full;
        bit err;
        logic [3:0] oh;
        logic [31:0] exp_rd;
        r = region(addr);
        full = 3 + rdy + rv;
        err = (r < 0) || (full > int'(TMO));
        lat = (r < 0) ? 1 : (err ? int'(TMO) : full);
        oh = (r < 0) ? 4'd0 : 4'b0001 << r;
        exp_rd = (err || we) ? 32'd0 : rd;
        check("ready_idle", m_req_ready, 1);
        m_req_valid = 1; m_addr = addr; m_we = we; m_wdata = wd; m_wstrb = ws;
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            check("s_valid", s_valid, (r >= 0 && k <= rdy + 1 && k < lat) ? oh : 4'd0);
            if (r >= 0 && k <= rdy + 1 && k < lat) begin
                check("s_addr", s_addr, addr);
                check("s_we", s_we, we);
                check("s_wdata", s_wdata, wd);
                check("s_wstrb", s_wstrb, ws);
            end
            check("rsp_valid", m_rsp_valid, k == lat);
            check("req_ready", m_req_ready, k == lat + 1);
            if (k == lat) begin
                check("rsp_err", m_rsp_err, err);
                check("rdata", m_rdata, exp_rd);
            end
            m_req_valid = (k <= lat);
            m_addr = $urandom; m_wdata = $urandom; m_we = 1'($urandom); m_wstrb = 4'($urandom);
            s_ready = (r >= 0 && k == rdy + 1) ? oh : 4'd0;
            s_rvalid = (r >= 0 && k == rdy + 2 + rv) ? oh : 4'd0;
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (r >= 0 && k == rdy + 2 + rv) s_rdata[32*r +: 32] = rd;
            if (noise) begin
                s_ready = s_ready | (4'($urandom) & ~oh);
                s_rvalid = s_rvalid | (4'($urandom) & ~oh);
                if (r >= 0 && k <= rdy + 1 && $urandom_range(0, 1) == 1) s_rvalid = s_rvalid | oh;
            end
        end
        m_req_valid = 0; s_ready = 0; s_rvalid = 0;
    endtask

    initial begin
        logic [31:0] a;
        int rg;
        rst = 1; m_req_valid = 0; m_addr = 0; m_we = 0; m_wdata = 0; m_wstrb = 0;
        s_ready = 0; s_rvalid = 0; s_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", m_req_ready, 0);
        check("rst_rsp_valid", m_rsp_valid, 0);
        check("rst_s_valid", s_valid, 0);
        check("rst_rdata", m_rdata, 0);
        rst = 0;
        @(negedge clk);

        transact(32'h1000_0010, 1'b0, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D, 1'b0);
        transact(32'h2000_0004, 1'b1, 32'h41, 4'b0001, 3, 0, 32'h1234_5678, 1'b0);
        transact(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0);
        transact(32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 40, 32'hDEAD_BEEF, 1'b0);
        transact(32'h3000_0010, 1'b0, 32'h0, 4'hF, 5, 0, 32'h0BAD_F00D, 1'b0);

        // reset while waiting for completion, slave answers afterwards
        m_req_valid = 1; m_addr = 32'h0000_0100; m_we = 0; m_wdata = 0; m_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("rr_s_valid", s_valid, 4'b0001);
        m_req_valid = 0; s_ready = 4'b0001;
        @(negedge clk);
        check("rr_s_valid_drop", s_valid, 0);
        s_ready = 0; rst = 1;
        @(negedge clk);
        check("rr_ready", m_req_ready, 0);
        check("rr_s_valid_rst", s_valid, 0);
        check("rr_rsp_valid", m_rsp_valid, 0);
        check("rr_s_addr", s_addr, 0);
        rst = 0; s_rvalid = 4'b0001; s_rdata = 128'h1111_2222;
        @(negedge clk);
        check("rr_no_rsp", m_rsp_valid, 0);
        check("rr_idle", m_req_ready, 1);
        s_rvalid = 0;
        @(negedge clk);
        check("rr_no_rsp2", m_rsp_valid, 0);

        // stray completion while idle, then back-to-back reads
        s_rvalid = 4'b1000;
        @(negedge clk);
        s_rvalid = 0;
        check("stray_rsp", m_rsp_valid, 0);
        check("stray_s_valid", s_valid, 0);
        transact(32'h0000_0040, 1'b0, 32'h0, 4'hF, 1, 1, 32'hA5A5_0001, 1'b0);
        transact(32'h1000_0080, 1'b0, 32'h0, 4'hF, 0, 2, 32'hA5A5_0002, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rg = $urandom_range(0, 4);
            a = $urandom;
            case (rg)
                0: a = {16'h0000, a[15:0]};
                1: a = {16'h1000, a[15:0]};
                2: a = {24'h2000_00, a[7:0]};
                3: a = {24'h3000_00, a[7:0]};
                default: a = a;
            endcase
            transact(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4),
                     $urandom_range(0, 5), $urandom, 1'b1);
        end
        @(negedge clk);
        check("end_rsp", m_rsp_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
